// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//
// Bundles the control inputs and IF/ID outputs of the instruction-fetch stage.
//
// Signals:
//   stall_i           hold PC and IF/ID register (load-use hazard)
//   redirect_i        take redirect target (taken branch, JAL, JALR)
//   redirect_target_i redirect PC from execute
//   instr_o           IF/ID instruction to decode
//   pc_o              IF/ID PC of instr_o
//   pc_plus4_o        IF/ID pc_o+4 (link value for JAL/JALR)
//   valid_o           IF/ID holds a real fetched instruction
//   pc_f_o            current fetch PC (debug/trace)
//   fetch_count_o     count of instructions accepted into IF/ID
//
// Modports:
//   master  the fetch stage (drives the outputs)
//   slave   the decode/execute side (drives stall and redirect)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic [31:0] pc_f_o;
  logic [31:0] fetch_count_o;

  modport master (
    input  stall_i,
    input  redirect_i,
    input  redirect_target_i,
    output instr_o,
    output pc_o,
    output pc_plus4_o,
    output valid_o,
    output pc_f_o,
    output fetch_count_o
  );

  modport slave (
    output stall_i,
    output redirect_i,
    output redirect_target_i,
    input  instr_o,
    input  pc_o,
    input  pc_plus4_o,
    input  valid_o,
    input  pc_f_o,
    input  fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Holds the fetch PC, reads a word-addressed
// instruction ROM combinationally, computes the next PC (sequential or
// redirect) and registers the fetched word into the IF/ID pipeline register
// with stall and flush control.
//
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   synchronous active-high reset
//   bus     fetch_stage_if.master: stall/redirect inputs, IF/ID outputs,
//           fetch PC and accepted-instruction counter
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter string       IMEM_FILE  = "program.hex",
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.master bus
);

  localparam int unsigned IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_f_q;
  logic [31:0] pc_f_d;
  logic [31:0] fetch_addr;
  logic [31:0] rom_word;
  logic        load_ifid;
  logic        flush_ifid;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic [31:0] count_q;

  logic [31:0] imem [IMEM_WORDS];

  // The two low target bits are always cleared, so they are never consumed.
  logic [1:0] unused_target_bits;
  assign unused_target_bits = bus.redirect_target_i[1:0];

  // BOOT fetches from RESET_PC explicitly; afterwards the PC register is the
  // fetch address. Words beyond the ROM read as a bubble rather than wrapping.
  always_comb begin
    fetch_addr = (state_q == BOOT) ? RESET_PC : pc_f_q;
    rom_word   = NOP_INSTR;
    if (fetch_addr[31:2] < 30'(IMEM_WORDS)) begin
      rom_word = imem[fetch_addr[IDX_W+1:2]];
    end
  end

  // Next-state and next-PC logic. Redirect beats stall because a stalled
  // instruction behind a taken branch is on the wrong path anyway.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    load_ifid  = 1'b0;
    flush_ifid = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (bus.redirect_i) begin
          pc_f_d     = {bus.redirect_target_i[31:2], 2'b00};
          flush_ifid = 1'b1;
        end else if (!bus.stall_i) begin
          pc_f_d    = RESET_PC + 32'd4;
          load_ifid = 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
        if (bus.redirect_i) begin
          pc_f_d     = {bus.redirect_target_i[31:2], 2'b00};
          flush_ifid = 1'b1;
        end else if (!bus.stall_i) begin
          pc_f_d    = pc_f_q + 32'd4;
          load_ifid = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, fetch PC, IF/ID register and counter. Stall simply leaves
  // everything untouched; a flush never bumps the counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_f_q     <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      if (flush_ifid) begin
        instr_q    <= NOP_INSTR;
        pc_q       <= 32'd0;
        pc_plus4_q <= 32'd0;
        valid_q    <= 1'b0;
      end else if (load_ifid) begin
        instr_q    <= rom_word;
        pc_q       <= fetch_addr;
        pc_plus4_q <= fetch_addr + 32'd4;
        valid_q    <= 1'b1;
        count_q    <= count_q + 32'd1;
      end
    end
  end

  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pc_plus4_q;
  assign bus.valid_o       = valid_q;
  assign bus.pc_f_o        = pc_f_q;
  assign bus.fetch_count_o = count_q;

endmodule
